// File: rtl/packet_ingress_arbiter.sv
// Round-robin ingress arbiter: merges NUM_PORTS AXI4-Stream sources into one stream,
// prefixing every forwarded packet with a header beat carrying its length and source port.
module packet_ingress_arbiter #(
    parameter int unsigned AXI_WIDTH = 64,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_PORTS-1:0][AXI_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_PORTS-1:0]                s_tvalid_i,
    input  logic [NUM_PORTS-1:0]                s_tlast_i,
    input  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0] s_tlen_i,
    output logic [NUM_PORTS-1:0]                s_tready_o,
    output logic [AXI_WIDTH-1:0]                m_tdata_o,
    output logic                                m_tvalid_o,
    output logic                                m_tlast_o,
    input  logic                                m_tready_i,
    output logic [2:0]                          grant_o,
    output logic                                busy_o,
    output logic [31:0]                         pkt_count_o
);

    localparam int unsigned MaxPorts = 8;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    state_e               state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [31:0]          pkt_count_q, pkt_count_d;

    // Inputs padded to 8 entries so a 3-bit port index can select them directly.
    logic [MaxPorts-1:0]                valid_pad, last_pad;
    logic [MaxPorts-1:0][AXI_WIDTH-1:0] data_pad;
    logic [MaxPorts-1:0][LEN_WIDTH-1:0] len_pad;

    for (genvar g = 0; g < MaxPorts; g++) begin : g_pad
        if (g < NUM_PORTS) begin : g_real
            assign valid_pad[g] = s_tvalid_i[g];
            assign last_pad[g]  = s_tlast_i[g];
            assign data_pad[g]  = s_tdata_i[g];
            assign len_pad[g]   = s_tlen_i[g];
        end else begin : g_none
            assign valid_pad[g] = 1'b0;
            assign last_pad[g]  = 1'b0;
            assign data_pad[g]  = '0;
            assign len_pad[g]   = '0;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ready
        assign s_tready_o[g] = (state_q == StPayload) && (grant_q == 3'(g)) && m_tready_i;
    end

    // First requester after the previous winner, wrapping at NUM_PORTS.
    logic        req_found;
    logic [2:0]  req_idx;
    int unsigned rr_pos;

    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        rr_pos    = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            rr_pos = 32'(last_grant_q) + k;
            if (rr_pos >= NUM_PORTS) rr_pos = rr_pos - NUM_PORTS;
            if (!req_found && valid_pad[3'(rr_pos)]) begin
                req_found = 1'b1;
                req_idx   = 3'(rr_pos);
            end
        end
    end

    logic [15:0]          hdr_len;
    logic [AXI_WIDTH-1:0] hdr_data;

    assign hdr_len = 16'(len_q);

    always_comb begin
        hdr_data                    = '0;
        hdr_data[AXI_WIDTH-1 -: 24] = {hdr_len, 5'd0, grant_q};
    end

    always_comb begin
        m_tdata_o  = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        case (state_q)
            StHeader: begin
                m_tvalid_o = 1'b1;
                m_tdata_o  = hdr_data;
            end
            StPayload: begin
                m_tdata_o  = data_pad[grant_q];
                m_tvalid_o = valid_pad[grant_q];
                m_tlast_o  = last_pad[grant_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            StIdle: begin
                if (req_found) begin
                    state_d = StHeader;
                    grant_d = req_idx;
                    len_d   = len_pad[req_idx];
                end
            end
            StHeader: begin
                if (m_tready_i) state_d = StPayload;
            end
            StPayload: begin
                if (m_tvalid_o && m_tready_i && m_tlast_o) begin
                    state_d      = StIdle;
                    last_grant_d = grant_q;
                    pkt_count_d  = pkt_count_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= 3'(NUM_PORTS - 1);
            len_q        <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign grant_o     = busy_o ? grant_q : 3'd0;
    assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_packet_ingress_arbiter.sv
// Bench for packet_ingress_arbiter: directed scenarios plus randomized traffic checked
// against a packet-level round-robin reference model.
module tb_packet_ingress_arbiter;

    localparam int AW = 64;
    localparam int NP = 4;
    localparam int LW = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0][AW-1:0]  s_tdata;
    logic [NP-1:0]          s_tvalid, s_tlast, s_tready;
    logic [NP-1:0][LW-1:0]  s_tlen;
    logic [AW-1:0]          m_tdata;
    logic                   m_tvalid, m_tlast, m_tready;
    logic [2:0]             grant;
    logic                   busy;
    logic [31:0]            pkt_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    packet_ingress_arbiter #(
        .AXI_WIDTH (AW),
        .NUM_PORTS (NP),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .s_tdata_i   (s_tdata),
        .s_tvalid_i  (s_tvalid),
        .s_tlast_i   (s_tlast),
        .s_tlen_i    (s_tlen),
        .s_tready_o  (s_tready),
        .m_tdata_o   (m_tdata),
        .m_tvalid_o  (m_tvalid),
        .m_tlast_o   (m_tlast),
        .m_tready_i  (m_tready),
        .grant_o     (grant),
        .busy_o      (busy),
        .pkt_count_o (pkt_count)
    );

    function automatic logic [63:0] hdr(input int p, input logic [15:0] len);
        hdr = {len, 8'(p), 40'h0};
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Returns just after a rising edge with reset released and all inputs idle.
    task automatic do_reset;
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tlen   = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        s_tvalid = '1;
        s_tlast  = '0;
        s_tdata  = '1;
        s_tlen   = '1;
        m_tready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || s_tready !== '0 ||
            busy !== 1'b0 || grant !== 3'd0 || pkt_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h rdy=%b busy=%b grant=%0d cnt=%0d want all zero",
                     m_tvalid, m_tlast, m_tdata, s_tready, busy, grant, pkt_count);
        end
        s_tvalid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0) begin
                bad++;
                $display("FAIL reset_idle: got busy=%b valid=%b rdy=%b want 0 0 0", busy, m_tvalid, s_tready);
            end
        end
    endtask

    task automatic test_single;
        logic [63:0] d [3];
        do_reset();
        for (int b = 0; b < 3; b++) d[b] = {$urandom, $urandom};
        m_tready    = 1'b1;
        s_tvalid[1] = 1'b1;
        s_tlen[1]   = 16'd17;
        s_tdata[1]  = d[0];
        s_tlast[1]  = 1'b0;
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'b0) begin
            bad++;
            $display("FAIL single_idle: got valid=%b rdy=%b want 0 0000", m_tvalid, s_tready);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_tlast !== 1'b0 || m_tdata !== 64'h0011_0100_0000_0000) begin
            bad++;
            $display("FAIL single_header: got valid=%b last=%b data=%h want 1 0 0011010000000000",
                     m_tvalid, m_tlast, m_tdata);
        end
        total++;
        if (grant !== 3'd1 || busy !== 1'b1 || s_tready !== 4'b0) begin
            bad++;
            $display("FAIL single_grant: got grant=%0d busy=%b rdy=%b want 1 1 0000", grant, busy, s_tready);
        end
        for (int b = 0; b < 3; b++) begin
            next_cycle();
            s_tdata[1] = d[b];
            s_tlast[1] = (b == 2);
            @(negedge clk);
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== d[b] || m_tlast !== (b == 2) || s_tready !== 4'b0010) begin
                bad++;
                $display("FAIL single_beat%0d: got valid=%b data=%h last=%b rdy=%b want 1 %h %b 0010",
                         b, m_tvalid, m_tdata, m_tlast, s_tready, d[b], (b == 2));
            end
        end
        next_cycle();
        s_tvalid[1] = 1'b0;
        s_tlast[1]  = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pkt_count !== 32'd1) begin
            bad++;
            $display("FAIL single_done: got busy=%b cnt=%0d want 0 1", busy, pkt_count);
        end
    endtask

    task automatic test_round_robin;
        int e;
        do_reset();
        m_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = 1'b1;
            s_tlast[p]  = 1'b1;
            s_tdata[p]  = 64'h0101_0101_0101_0101 * 64'(p + 1);
            s_tlen[p]   = 16'(8 + p);
        end
        for (int i = 0; i < 5; i++) begin
            e = i % NP;
            @(negedge clk);
            total++;
            if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_idle%0d: got valid=%b busy=%b want 0 0", i, m_tvalid, busy);
            end
            next_cycle();
            @(negedge clk);
            total++;
            if (m_tdata !== hdr(e, 16'(8 + e)) || grant !== 3'(e)) begin
                bad++;
                $display("FAIL rr_header%0d: got data=%h grant=%0d want %h %0d",
                         i, m_tdata, grant, hdr(e, 16'(8 + e)), e);
            end
            next_cycle();
            @(negedge clk);
            total++;
            if (s_tready !== 4'(1 << e) || m_tlast !== 1'b1 ||
                m_tdata !== 64'h0101_0101_0101_0101 * 64'(e + 1)) begin
                bad++;
                $display("FAIL rr_payload%0d: got rdy=%b last=%b data=%h want %b 1 port %0d data",
                         i, s_tready, m_tlast, m_tdata, 4'(1 << e), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_header_stall;
        logic [63:0] d0, d1;
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        do_reset();
        s_tvalid[0] = 1'b1;
        s_tlen[0]   = 16'd12;
        s_tdata[0]  = d0;
        s_tlast[0]  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== hdr(0, 16'd12) || s_tready !== 4'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: got valid=%b data=%h rdy=%b want 1 %h 0000",
                         k, m_tvalid, m_tdata, s_tready, hdr(0, 16'd12));
            end
        end
        next_cycle();
        m_tready = 1'b1;
        @(negedge clk);
        total++;
        if (m_tdata !== hdr(0, 16'd12) || s_tready !== 4'b0) begin
            bad++;
            $display("FAIL stall_release: got data=%h rdy=%b want %h 0000", m_tdata, s_tready, hdr(0, 16'd12));
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (s_tready !== 4'b0001 || m_tdata !== d0 || m_tlast !== 1'b0) begin
            bad++;
            $display("FAIL stall_payload: got rdy=%b data=%h last=%b want 0001 %h 0", s_tready, m_tdata, m_tlast, d0);
        end
        next_cycle();
        s_tdata[0] = d1;
        s_tlast[0] = 1'b1;
        @(negedge clk);
        next_cycle();
        s_tvalid[0] = 1'b0;
        s_tlast[0]  = 1'b0;
        @(negedge clk);
        total++;
        if (pkt_count !== 32'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_done: got cnt=%0d busy=%b want 1 0", pkt_count, busy);
        end
    endtask

    task automatic test_grant_hold;
        logic [63:0] d [3];
        for (int b = 0; b < 3; b++) d[b] = {$urandom, $urandom};
        do_reset();
        m_tready    = 1'b1;
        s_tvalid[2] = 1'b1;
        s_tlen[2]   = 16'd24;
        s_tdata[2]  = d[0];
        @(negedge clk);
        next_cycle();
        s_tvalid[0] = 1'b1;
        s_tlen[0]   = 16'd8;
        s_tdata[0]  = 64'hA5A5_0000_0000_5A5A;
        s_tlast[0]  = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 3'd2 || m_tdata !== hdr(2, 16'd24)) begin
            bad++;
            $display("FAIL hold_header: got grant=%0d data=%h want 2 %h", grant, m_tdata, hdr(2, 16'd24));
        end
        next_cycle();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            next_cycle();
            s_tvalid[2] = 1'b0;
            @(negedge clk);
            total++;
            if (m_tvalid !== 1'b0 || s_tready !== 4'b0100 || grant !== 3'd2) begin
                bad++;
                $display("FAIL hold_gap%0d: got valid=%b rdy=%b grant=%0d want 0 0100 2", g, m_tvalid, s_tready, grant);
            end
        end
        for (int b = 1; b < 3; b++) begin
            next_cycle();
            s_tvalid[2] = 1'b1;
            s_tdata[2]  = d[b];
            s_tlast[2]  = (b == 2);
            @(negedge clk);
            total++;
            if (m_tdata !== d[b] || s_tready !== 4'b0100 || m_tlast !== (b == 2)) begin
                bad++;
                $display("FAIL hold_beat%0d: got data=%h rdy=%b last=%b want %h 0100 %b",
                         b, m_tdata, s_tready, m_tlast, d[b], (b == 2));
            end
        end
        next_cycle();
        s_tvalid[2] = 1'b0;
        s_tlast[2]  = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        total++;
        if (grant !== 3'd0 || m_tdata !== hdr(0, 16'd8)) begin
            bad++;
            $display("FAIL hold_next: got grant=%0d data=%h want 0 %h", grant, m_tdata, hdr(0, 16'd8));
        end
        next_cycle();
        @(negedge clk);
        next_cycle();
        s_tvalid[0] = 1'b0;
        @(negedge clk);
        total++;
        if (pkt_count !== 32'd2) begin
            bad++;
            $display("FAIL hold_count: got %0d want 2", pkt_count);
        end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        m_tready    = 1'b1;
        s_tvalid[0] = 1'b1;
        s_tlast[0]  = 1'b1;
        s_tlen[0]   = 16'd4;
        s_tdata[0]  = 64'h1234;
        repeat (2) begin
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);
        next_cycle();
        s_tvalid[0] = 1'b0;
        s_tlast[0]  = 1'b0;
        s_tvalid[1] = 1'b1;
        s_tlen[1]   = 16'd24;
        s_tdata[1]  = 64'h1111;
        @(negedge clk);
        total++;
        if (pkt_count !== 32'd1) begin
            bad++;
            $display("FAIL rmid_precount: got %0d want 1", pkt_count);
        end
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        s_tdata[1] = 64'h2222;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || s_tready !== '0 ||
            busy !== 1'b0 || grant !== 3'd0 || pkt_count !== 32'd0) begin
            bad++;
            $display("FAIL rmid_async: got valid=%b last=%b data=%h rdy=%b busy=%b grant=%0d cnt=%0d want all zero",
                     m_tvalid, m_tlast, m_tdata, s_tready, busy, grant, pkt_count);
        end
        s_tvalid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        s_tvalid[3] = 1'b1;
        s_tlast[3]  = 1'b1;
        s_tlen[3]   = 16'd5;
        s_tdata[3]  = 64'h3333;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        total++;
        if (m_tdata !== hdr(3, 16'd5) || grant !== 3'd3) begin
            bad++;
            $display("FAIL rmid_header: got data=%h grant=%0d want %h 3", m_tdata, grant, hdr(3, 16'd5));
        end
        next_cycle();
        @(negedge clk);
        next_cycle();
        s_tvalid[3] = 1'b0;
        @(negedge clk);
        total++;
        if (pkt_count !== 32'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_count: got cnt=%0d busy=%b want 1 0", pkt_count, busy);
        end
    endtask

    // Sources hold each beat until accepted; the model tracks arbitration per packet.
    task automatic test_random;
        bit          active [NP];
        bit          acc    [NP];
        int          nbeats [NP];
        int          idx    [NP];
        logic [15:0] plen   [NP];
        logic [63:0] pdata  [NP][4];
        int          gen, done, cycles, phase, mlast, mgrant, c;
        bit          found;
        logic [31:0] exp_count;
        int          npkts;
        npkts = 1000;
        do_reset();
        gen = 0; done = 0; cycles = 0; phase = 0; mlast = NP - 1; mgrant = 0; exp_count = 0;
        for (int p = 0; p < NP; p++) begin
            active[p] = 1'b0;
            acc[p]    = 1'b0;
            idx[p]    = 0;
            nbeats[p] = 1;
            plen[p]   = '0;
        end
        while (done < npkts && cycles < 60000) begin
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    idx[p]++;
                    if (idx[p] == nbeats[p]) active[p] = 1'b0;
                end
                acc[p] = 1'b0;
                if (!active[p] && gen < npkts && $urandom_range(0, 2) == 0) begin
                    active[p] = 1'b1;
                    idx[p]    = 0;
                    gen++;
                    plen[p]   = 16'($urandom_range(0, 24));
                    nbeats[p] = (plen[p] == 0) ? 1 : (int'(plen[p]) + 7) / 8;
                    for (int b = 0; b < 4; b++) pdata[p][b] = {$urandom, $urandom};
                end
                s_tvalid[p] = active[p] && ($urandom_range(0, 3) != 0);
                s_tlast[p]  = active[p] && (idx[p] == nbeats[p] - 1);
                s_tdata[p]  = active[p] ? pdata[p][idx[p]] : 64'h0;
                s_tlen[p]   = plen[p];
            end
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            case (phase)
                0: begin
                    total++;
                    if (m_tvalid !== 1'b0 || s_tready !== 4'b0 || busy !== 1'b0 || pkt_count !== exp_count) begin
                        bad++;
                        $display("FAIL rand_idle: got valid=%b rdy=%b busy=%b cnt=%0d want 0 0000 0 %0d",
                                 m_tvalid, s_tready, busy, pkt_count, exp_count);
                    end
                    found = 1'b0;
                    for (int k = 1; k <= NP; k++) begin
                        c = (mlast + k) % NP;
                        if (!found && s_tvalid[c]) begin
                            found  = 1'b1;
                            mgrant = c;
                        end
                    end
                    if (found) phase = 1;
                end
                1: begin
                    total++;
                    if (m_tvalid !== 1'b1 || m_tlast !== 1'b0 || s_tready !== 4'b0 ||
                        m_tdata !== hdr(mgrant, plen[mgrant]) || grant !== 3'(mgrant)) begin
                        bad++;
                        $display("FAIL rand_header: got valid=%b last=%b rdy=%b data=%h grant=%0d want 1 0 0000 %h %0d",
                                 m_tvalid, m_tlast, s_tready, m_tdata, grant, hdr(mgrant, plen[mgrant]), mgrant);
                    end
                    if (m_tready) phase = 2;
                end
                default: begin
                    total++;
                    if (s_tready !== (m_tready ? 4'(1 << mgrant) : 4'b0) || grant !== 3'(mgrant) ||
                        m_tvalid !== s_tvalid[mgrant]) begin
                        bad++;
                        $display("FAIL rand_route: got rdy=%b grant=%0d valid=%b want %b %0d %b",
                                 s_tready, grant, m_tvalid, (m_tready ? 4'(1 << mgrant) : 4'b0),
                                 mgrant, s_tvalid[mgrant]);
                    end
                    if (s_tvalid[mgrant]) begin
                        total++;
                        if (m_tdata !== pdata[mgrant][idx[mgrant]] ||
                            m_tlast !== (idx[mgrant] == nbeats[mgrant] - 1)) begin
                            bad++;
                            $display("FAIL rand_beat: port %0d beat %0d got data=%h last=%b want %h %b",
                                     mgrant, idx[mgrant], m_tdata, m_tlast, pdata[mgrant][idx[mgrant]],
                                     (idx[mgrant] == nbeats[mgrant] - 1));
                        end
                        if (m_tready) begin
                            acc[mgrant] = 1'b1;
                            if (idx[mgrant] == nbeats[mgrant] - 1) begin
                                phase = 0;
                                mlast = mgrant;
                                exp_count++;
                                done++;
                            end
                        end
                    end
                end
            endcase
            cycles++;
            next_cycle();
        end
        total++;
        if (done != npkts) begin
            bad++;
            $display("FAIL rand_complete: got %0d packets in %0d cycles want %0d", done, cycles, npkts);
        end
        total++;
        if (pkt_count !== exp_count) begin
            bad++;
            $display("FAIL rand_count: got %0d want %0d", pkt_count, exp_count);
        end
        s_tvalid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_header_stall();
        test_grant_hold();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_ingress_arbiter.md
PACKET_INGRESS_ARBITER -- requirements
Module: packet_ingress_arbiter

Interface
REQ-001 The block SHALL have parameter AXI_WIDTH, default 64, the data width of all AXI4-Stream ports in bits.
REQ-002 The block SHALL have parameter NUM_PORTS, default 4, the number of ingress requesters (range 2..8).
REQ-003 The block SHALL have parameter LEN_WIDTH, default 16, the width of the packet length sideband.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 s_tdata_i  input  [NUM_PORTS][AXI_WIDTH]  per-port payload beat, byte 0 in the MSB byte.
REQ-008 s_tvalid_i  input  [NUM_PORTS]  per-port beat valid.
REQ-009 s_tlast_i  input  [NUM_PORTS]  per-port last beat of packet.
REQ-010 s_tlen_i  input  [NUM_PORTS][LEN_WIDTH]  packet byte length, stable from first tvalid of a packet until its first beat is accepted.
REQ-011 s_tready_o  output  [NUM_PORTS]  per-port beat accept.
REQ-012 m_tdata_o  output  AXI_WIDTH  merged stream to packet_buffer tdata_i.
REQ-013 m_tvalid_o / m_tlast_o  output  1 each  merged stream valid / last.
REQ-014 m_tready_i  input  1  downstream ready from packet_buffer tready_o.
REQ-015 grant_o  output  3  index of port currently owning the output; valid while busy_o=1.
REQ-016 busy_o  output  1  high in HEADER and PAYLOAD states.
REQ-017 pkt_count_o  output  32  total packets forwarded, wraps at 2^32.

Function
REQ-018 The FSM SHALL have states IDLE, HEADER, PAYLOAD.
REQ-019 In IDLE, s_tready_o SHALL be all-zero and m_tvalid_o SHALL be 0.
REQ-020 In IDLE with any s_tvalid_i set, the block SHALL grant the first requesting port in round-robin order starting at (last_grant+1) mod NUM_PORTS, latch its s_tlen_i and index, and enter HEADER next cycle.
REQ-021 In HEADER, m_tvalid_o=1, m_tlast_o=0, m_tdata_o = {len[15:0], 8-bit port index, zeros} with length in bits [AXI_WIDTH-1 -: 16], port index in the next 8 bits, and all lower bits 0.
REQ-022 HEADER SHALL hold m_tdata_o stable until m_tready_i=1, then enter PAYLOAD.
REQ-023 In PAYLOAD, the output SHALL pass through combinationally from the granted port: m_tdata/m_tvalid/m_tlast from that port, its s_tready_o = m_tready_i, and all other s_tready_o = 0.
REQ-024 A PAYLOAD beat with m_tvalid_o, m_tready_i and m_tlast_o all high SHALL return the FSM to IDLE, update last_grant, and increment pkt_count_o in that cycle.
REQ-025 Latency SHALL be one cycle from a request seen in IDLE to header valid.
REQ-026 The minimum gap SHALL be one IDLE cycle between the last beat of one packet and the next header.
REQ-027 A request deasserted while in IDLE before grant SHALL be ignored; once granted, the grant SHALL persist until tlast regardless of tvalid gaps.
REQ-028 A granted packet of length 0 or with a mismatched beat count SHALL still be forwarded until tlast; the length field is not checked.
REQ-029 Ports not granted SHALL never see s_tready_o=1; no beat is ever accepted from two ports in one cycle.

Reset
REQ-030 On rst_i assertion, at any time including mid-packet, the block SHALL immediately set state=IDLE, s_tready_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, grant_o=0, busy_o=0, pkt_count_o=0, and last_grant=NUM_PORTS-1, so that port 0 has first priority.
REQ-031 A packet truncated by reset SHALL NOT be resumed after rst_i deasserts.

Verification
REQ-032 Single port 1, 17-byte packet (3 beats), m_tready_i=1 -> header 0x0011_01_0000000000 one cycle after request, 3 payload beats, tlast on the 3rd, pkt_count_o=1.
REQ-033 All 4 ports request continuously after reset -> grant order 0,1,2,3,0 and header port index fields match.
REQ-034 m_tready_i=0 for 5 cycles during HEADER -> header held stable; no s_tready_o asserted; PAYLOAD entered on the first ready cycle.
REQ-035 Port 2 granted, tvalid gaps mid-packet while port 0 requests -> port 2 keeps the grant until its tlast; port 0 is served next.
REQ-036 rst_i pulsed during PAYLOAD beat 2 -> all outputs zero asynchronously; after release with port 3 requesting, header shows port 3 and pkt_count_o=1 after completion.
REQ-037 Random traffic of 1000 packets on all ports with random m_tready_i, checked by a scoreboard -> every packet reaches packet_buffer intact, in per-port order, with correct header fields.
